accelerator_host_loader: RTL and testbench

//  Host-side driver for the HD accelerator load/result interface. Accepts one 32-bit host word

---
 rtl/hd_host_pkg.sv | 38 +++
 rtl/accelerator_host_loader_phase_counter.sv | 28 ++
 rtl/accelerator_host_loader.sv | 186 ++++++++++++++++++
 tb/tb_accelerator_host_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_host_pkg.sv
// Shared types and defaults for the HD accelerator host loader.
// Holds the loader state encoding and phase sequencing helper.
package hd_host_pkg;

  localparam int HOST_WIDTH      = 32;
  localparam int DEF_PROJ_BEATS  = 125;
  localparam int DEF_FEAT_BEATS  = 514;
  localparam int DEF_CLASS_BEATS = 104000;
  localparam int DEF_NUM_CLASSES = 26;
  localparam int DEF_CNT_WIDTH   = 17;
  localparam int DEF_TIMEOUT     = 65535;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARST,
    S_PROJ,
    S_FEAT,
    S_CLASS,
    S_WAIT,
    S_RESULT
  } loader_state_t;

  // Next load phase after s, skipping phases configured with zero beats.
  function automatic loader_state_t phase_after(
    input loader_state_t s,
    input int            pb,
    input int            fb,
    input int            cb
  );
    loader_state_t n;
    n = S_WAIT;
    if (cb != 0 && s != S_CLASS) n = S_CLASS;
    if (fb != 0 && (s == S_ARST || s == S_PROJ)) n = S_FEAT;
    if (pb != 0 && s == S_ARST) n = S_PROJ;
    return n;
  endfunction

endpackage

// File: rtl/accelerator_host_loader_phase_counter.sv
// Beat counter for one load phase: counts accepted beats up to a limit,
// wraps to zero on the last beat and flags that beat.
module phase_counter #(
  parameter int CNT_WIDTH = 17
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clr,
  input  logic                 i_inc,
  input  logic [CNT_WIDTH-1:0] i_limit,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_last
);

  logic [CNT_WIDTH-1:0] r_count;

  assign o_count = r_count;
  assign o_last  = (r_count == i_limit - CNT_WIDTH'(1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_last ? '0 : r_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/accelerator_host_loader.sv
// Host-side loader: streams host words into the accelerator's projection,
// feature and class write ports, then waits for and holds the result.
module accelerator_host_loader
  import hd_host_pkg::*;
#(
  parameter int PROJ_BEATS  = DEF_PROJ_BEATS,
  parameter int FEAT_BEATS  = DEF_FEAT_BEATS,
  parameter int CLASS_BEATS = DEF_CLASS_BEATS,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [HOST_WIDTH-1:0] host_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  output logic                  acc_reset,
  output logic                  projection_write,
  output logic                  feature_write,
  output logic                  class_write,
  output logic [1:0][15:0]      projections_in,
  output logic [31:0]           feature_in,
  output logic [7:0]            class_in,
  output logic [15:0]           coeffs_in,
  input  logic [15:0]           max_val,
  input  logic [15:0]           max_index,
  input  logic                  all_done,
  output logic [15:0]           result_val,
  output logic [15:0]           result_index,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic                  busy,
  output logic                  error
);

  loader_state_t        r_state;
  logic [15:0]          r_tmo;
  logic                 r_acc_reset;
  logic                 r_pw;
  logic                 r_fw;
  logic                 r_cw;
  logic [1:0][15:0]     r_proj;
  logic [31:0]          r_feat;
  logic [7:0]           r_cls;
  logic [15:0]          r_coef;
  logic [15:0]          r_rval;
  logic [15:0]          r_ridx;
  logic                 r_rvalid;
  logic                 r_err;

  logic                 w_ready;
  logic                 w_beat;
  logic                 w_last;
  logic [CNT_WIDTH-1:0] w_count;
  logic [CNT_WIDTH-1:0] w_limit;

  assign w_ready = (r_state == S_PROJ) ||
                   (r_state == S_FEAT) ||
                   (r_state == S_CLASS);
  assign w_beat  = host_valid && w_ready;

  always_comb begin
    w_limit = '0;
    case (r_state)
      S_PROJ:  w_limit = CNT_WIDTH'(PROJ_BEATS);
      S_FEAT:  w_limit = CNT_WIDTH'(FEAT_BEATS);
      S_CLASS: w_limit = CNT_WIDTH'(CLASS_BEATS);
      default: w_limit = '0;
    endcase
  end

  phase_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_phase_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (r_state == S_ARST),
    .i_inc   (w_beat),
    .i_limit (w_limit),
    .o_count (w_count),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tmo       <= '0;
      r_acc_reset <= 1'b1;
      r_pw        <= 1'b0;
      r_fw        <= 1'b0;
      r_cw        <= 1'b0;
      r_proj      <= '0;
      r_feat      <= '0;
      r_cls       <= '0;
      r_coef      <= '0;
      r_rval      <= '0;
      r_ridx      <= '0;
      r_rvalid    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pw        <= 1'b0;
      r_fw        <= 1'b0;
      r_cw        <= 1'b0;
      r_acc_reset <= 1'b0;
      r_tmo       <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_ARST;
            r_acc_reset <= 1'b1;
          end
        end
        S_ARST: begin
          r_err   <= 1'b0;
          r_state <= phase_after(S_ARST, PROJ_BEATS,
                                 FEAT_BEATS, CLASS_BEATS);
        end
        S_PROJ: begin
          if (w_beat) begin
            r_pw   <= 1'b1;
            r_proj <= host_data;
            if (w_last)
              r_state <= phase_after(S_PROJ, PROJ_BEATS,
                                     FEAT_BEATS, CLASS_BEATS);
          end
        end
        S_FEAT: begin
          if (w_beat) begin
            r_fw   <= 1'b1;
            r_feat <= host_data;
            if (w_last)
              r_state <= phase_after(S_FEAT, PROJ_BEATS,
                                     FEAT_BEATS, CLASS_BEATS);
          end
        end
        S_CLASS: begin
          if (w_beat) begin
            r_cw  <= 1'b1;
            r_cls <= host_data[7:0];
            if (w_count < CNT_WIDTH'(NUM_CLASSES))
              r_coef <= host_data[31:16];
            if (w_last) r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Saturating count of cycles spent without all_done.
          r_tmo <= (r_tmo == '1) ? r_tmo : r_tmo + 16'd1;
          if (all_done) begin
            r_rval   <= max_val;
            r_ridx   <= max_index;
            r_rvalid <= 1'b1;
            r_state  <= S_RESULT;
          end else if (r_tmo == 16'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_RESULT: begin
          if (result_ack) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host_ready       = w_ready;
  assign busy             = (r_state != S_IDLE);
  assign acc_reset        = r_acc_reset;
  assign projection_write = r_pw;
  assign feature_write    = r_fw;
  assign class_write      = r_cw;
  assign projections_in   = r_proj;
  assign feature_in       = r_feat;
  assign class_in         = r_cls;
  assign coeffs_in        = r_coef;
  assign result_val       = r_rval;
  assign result_index     = r_ridx;
  assign result_valid     = r_rvalid;
  assign error            = r_err;

endmodule

// File: tb/tb_accelerator_host_loader.sv
// Randomized bench for accelerator_host_loader with a cycle-level
// reference model of the load/result protocol.
module tb_accelerator_host_loader;

  localparam int P   = 2;
  localparam int F   = 2;
  localparam int C   = 3;
  localparam int NC  = 2;
  localparam int CW  = 4;
  localparam int TMO = 16;
  localparam int TOT = P + F + C;

  logic            clk;
  logic            reset;
  logic            start;
  logic [31:0]     host_data;
  logic            host_valid;
  logic            host_ready;
  logic            acc_reset;
  logic            projection_write;
  logic            feature_write;
  logic            class_write;
  logic [1:0][15:0] projections_in;
  logic [31:0]     feature_in;
  logic [7:0]      class_in;
  logic [15:0]     coeffs_in;
  logic [15:0]     max_val;
  logic [15:0]     max_index;
  logic            all_done;
  logic [15:0]     result_val;
  logic [15:0]     result_index;
  logic            result_valid;
  logic            result_ack;
  logic            busy;
  logic            error;

  int n_chk = 0;
  int n_err = 0;

  accelerator_host_loader #(
    .PROJ_BEATS  (P),
    .FEAT_BEATS  (F),
    .CLASS_BEATS (C),
    .NUM_CLASSES (NC),
    .CNT_WIDTH   (CW),
    .TIMEOUT     (TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .host_data        (host_data),
    .host_valid       (host_valid),
    .host_ready       (host_ready),
    .acc_reset        (acc_reset),
    .projection_write (projection_write),
    .feature_write    (feature_write),
    .class_write      (class_write),
    .projections_in   (projections_in),
    .feature_in       (feature_in),
    .class_in         (class_in),
    .coeffs_in        (coeffs_in),
    .max_val          (max_val),
    .max_index        (max_index),
    .all_done         (all_done),
    .result_val       (result_val),
    .result_index     (result_index),
    .result_valid     (result_valid),
    .result_ack       (result_ack),
    .busy             (busy),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: 0 idle, 1 acc reset, 2 loading, 3 waiting, 4 result
  int          mph   = 0;
  int          nacc  = 0;
  int          m_tmo = 0;
  bit          m_err = 0;
  logic [15:0] m_rv  = 0;
  logic [15:0] m_ri  = 0;
  logic [31:0] h_proj = 0;
  logic [31:0] h_feat = 0;
  logic [7:0]  h_cls  = 0;
  logic [15:0] h_coef = 0;
  bit          p_rst = 1;
  bit          p_start, p_valid, p_done, p_ack;
  logic [31:0] p_data;
  logic [15:0] p_mv, p_mi;

  always @(negedge clk) begin
    logic [2:0] exp_wr;
    exp_wr = 3'b000;
    if (p_rst) begin
      mph = 0; nacc = 0; m_tmo = 0; m_err = 0;
      m_rv = 0; m_ri = 0;
      h_proj = 0; h_feat = 0; h_cls = 0; h_coef = 0;
    end else begin
      case (mph)
        0: if (p_start) begin mph = 1; nacc = 0; end
        1: begin mph = 2; m_err = 0; end
        2: if (p_valid) begin
          if (nacc < P) begin
            exp_wr = 3'b100; h_proj = p_data;
          end else if (nacc < P + F) begin
            exp_wr = 3'b010; h_feat = p_data;
          end else begin
            exp_wr = 3'b001; h_cls = p_data[7:0];
            if (nacc - P - F < NC) h_coef = p_data[31:16];
          end
          nacc++;
          if (nacc == TOT) begin mph = 3; m_tmo = 0; end
        end
        3: if (p_done) begin
          m_rv = p_mv; m_ri = p_mi; mph = 4;
        end else begin
          m_tmo++;
          if (m_tmo == TMO) begin m_err = 1; mph = 0; end
        end
        4: if (p_ack) mph = 0;
        default: mph = 0;
      endcase
    end
    chk("strobes", {projection_write, feature_write, class_write}, exp_wr);
    chk("proj_data", projections_in, h_proj);
    chk("feat_data", feature_in, h_feat);
    chk("class_data", class_in, h_cls);
    chk("coeff_data", coeffs_in, h_coef);
    chk("host_ready", host_ready, mph == 2);
    chk("busy", busy, mph != 0);
    chk("acc_reset", acc_reset, p_rst || mph == 1);
    chk("error", error, m_err);
    chk("res_valid", result_valid, mph == 4);
    chk("res_val", result_val, m_rv);
    chk("res_idx", result_index, m_ri);
    p_rst   = reset;
    p_start = start;
    p_valid = host_valid;
    p_data  = host_data;
    p_done  = all_done;
    p_ack   = result_ack;
    p_mv    = max_val;
    p_mi    = max_index;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // prob < 0 toggles host_valid every cycle
  task automatic do_load(input int prob, input bit seq, input bit noise,
                         input int abort_at);
    int n;
    int guard;
    bit acc;
    n = 0;
    guard = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    while (mph != 3 && guard < 500) begin
      if (abort_at >= 0 && nacc >= abort_at) begin
        host_valid = 1'b0;
        start = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", host_ready, 0);
        chk("abort_strobes",
            {projection_write, feature_write, class_write}, 0);
        return;
      end
      if (noise) start = ($urandom_range(7) == 0);
      if (prob < 0) host_valid = ~host_valid;
      else host_valid = ($urandom_range(99) < prob);
      host_data = seq ? n : $urandom;
      acc = host_valid && host_ready;
      cyc();
      if (acc) n++;
      guard++;
    end
    chk("load_guard", guard < 500, 1);
    host_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_result(input int dly, input logic [15:0] mv,
                           input logic [15:0] mi);
    repeat (dly) cyc();
    all_done = 1'b1;
    max_val = mv;
    max_index = mi;
    cyc();
    all_done = 1'b0;
    max_val = 16'($urandom);
    max_index = 16'($urandom);
    repeat (2) begin
      start = 1'b1;
      cyc();
    end
    start = 1'b0;
    chk("hold_val", result_val, mv);
    chk("hold_idx", result_index, mi);
    chk("hold_valid", result_valid, 1);
    result_ack = 1'b1;
    start = 1'b1;
    cyc();
    result_ack = 1'b0;
    start = 1'b0;
    chk("ack_busy", busy, 0);
    chk("ack_valid", result_valid, 0);
    cyc();
    chk("idle_busy", busy, 0);
  endtask

  task automatic do_timeout();
    repeat (TMO + 4) cyc();
    chk("tmo_error", error, 1);
    chk("tmo_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    host_data = '0;
    host_valid = 1'b0;
    all_done = 1'b0;
    max_val = '0;
    max_index = '0;
    result_ack = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_ready", host_ready, 0);

    do_load(100, 1, 0, -1);
    chk("t1_feat", feature_in, 3);
    chk("t1_class", class_in, 6);
    chk("t1_coeff", coeffs_in, 0);
    do_result(2, 16'h00AB, 16'h0007);

    do_load(-1, 0, 0, -1);
    do_result(0, 16'($urandom), 16'($urandom));

    do_load(70, 0, 1, -1);
    do_timeout();
    do_load(100, 0, 0, -1);
    chk("err_clear", error, 0);
    do_result(5, 16'($urandom), 16'($urandom));

    do_load(100, 1, 0, P);
    do_load(100, 1, 0, -1);
    chk("reload_class", class_in, 6);
    do_result(1, 16'h1234, 16'h0019);

    for (int i = 0; i < 10; i++) begin
      do_load(int'($urandom_range(100, 30)), 0, 1, -1);
      if ($urandom_range(3) == 0) do_timeout();
      else do_result(int'($urandom_range(8)), 16'($urandom),
                     16'($urandom));
    end

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
